ad_ip_jesd204_tpl_dac_dma_fifo: RTL and testbench

Elastic buffer directly upstream of the JESD204 TPL DAC core. Accepts DMA sample words over a valid/ready stream and presents them as `dac_ddata` on each cycle the TPL core asserts its valid strobe. Controls start-up with a prefill threshold and zero-fills the output on starvation. Reports each underflow event so software can detect glitched playback.

---
 rtl/ad_ip_jesd204_tpl_dac_dma_fifo_pkg.sv | 21 ++
 rtl/ad_ip_jesd204_tpl_dac_fifo_mem.sv | 61 ++++++
 rtl/ad_ip_jesd204_tpl_dac_dma_fifo.sv | 142 ++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_dma_fifo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo_pkg.sv
//==============================================================================
// Module   : ad_ip_jesd204_tpl_dac_dma_fifo_pkg
// Purpose  : Shared types for the TPL DAC DMA elastic buffer. Holds the
//            playback state encoding used by the top level.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package ad_ip_jesd204_tpl_dac_dma_fifo_pkg;

  // Playback state. The encodings are fixed so that software and debug
  // tooling can decode a probed state register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } dac_fifo_state_e;

endpackage

`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_fifo_mem.sv
//==============================================================================
// Module   : ad_ip_jesd204_tpl_dac_fifo_mem
// Purpose  : Simple dual-port RAM, one write port and one synchronous read
//            port. The read register doubles as the sample output register
//            and has a synchronous clear used for zero-fill.
// Ports    : clk                        - clock
//            i_wr_en/i_wr_addr/i_wr_data - write port
//            i_rd_en/i_rd_addr          - read port, data on o_rd_data after edge
//            i_rd_clr                   - load zero into the read register
//                                         (priority over i_rd_en)
//            o_rd_data                  - registered read data
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ad_ip_jesd204_tpl_dac_fifo_mem #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic                  i_rd_clr,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  // The FIFO never reads and writes the same address in one cycle (that
  // would require it to be both empty and full), so no bypass is needed.
  always_comb begin
    rd_data_d = rd_data_q;
    if (i_rd_clr) begin
      rd_data_d = '0;
    end else if (i_rd_en) begin
      rd_data_d = mem_q[i_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign o_rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo.sv
//==============================================================================
// Module   : ad_ip_jesd204_tpl_dac_dma_fifo
// Purpose  : Elastic buffer between the DMA stream and the JESD204 TPL DAC
//            core. Prefills to a threshold before playback, zero-fills on
//            starvation and pulses dac_dunf once per underflow event.
// Ports    : clk          - DAC link clock
//            resetn       - synchronous active-low reset
//            dac_enable   - playback enable, low flushes the buffer
//            s_axis_*     - DMA sample stream (valid/ready/data)
//            dac_valid    - TPL consume strobe
//            dac_ddata    - registered sample word to the TPL core
//            dac_dunf     - one-cycle underflow pulse
//            fifo_level   - occupancy, 0..2^DEPTH_LOG2
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ad_ip_jesd204_tpl_dac_dma_fifo
  import ad_ip_jesd204_tpl_dac_dma_fifo_pkg::*;
#(
  parameter int DMA_DATA_WIDTH = 128,
  parameter int DEPTH_LOG2     = 4,
  parameter int PREFILL        = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      dac_enable,
  input  logic                      s_axis_valid,
  output logic                      s_axis_ready,
  input  logic [DMA_DATA_WIDTH-1:0] s_axis_data,
  input  logic                      dac_valid,
  output logic [DMA_DATA_WIDTH-1:0] dac_ddata,
  output logic                      dac_dunf,
  output logic [DEPTH_LOG2:0]       fifo_level
);

  localparam int               PTR_W       = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] PREFILL_LVL = PTR_W'(PREFILL);

  dac_fifo_state_e  state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             dac_dunf_q, dac_dunf_d;

  logic [PTR_W-1:0] level;
  logic             empty;
  logic             full;
  logic             ready;
  logic             push;
  logic             pop;
  logic             starve;
  logic             rd_clr;

  // Extra pointer MSB separates full from empty; level wraps naturally.
  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                 (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);

  // Ready depends only on registered state: a pop in a full cycle does not
  // open a slot until the following cycle.
  assign ready  = (state_q != ST_IDLE) && !full;
  assign push   = s_axis_valid && ready;
  // Empty is judged on registered pointers, so a same-cycle push cannot
  // rescue a pop on an empty buffer.
  assign pop    = dac_valid && (state_q == ST_RUN) && !empty;
  assign starve = dac_valid && (state_q == ST_RUN) && empty;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dac_dunf_d = 1'b0;
    if (!dac_enable) begin
      // Flush: any push offered in this cycle is dropped.
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop};
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FILL;
        end
        ST_FILL: begin
          if (level >= PREFILL_LVL) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (starve) begin
            state_d    = ST_FILL;
            dac_dunf_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dac_dunf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dac_dunf_q <= dac_dunf_d;
    end
  end

  // Outside RUN the output register only ever carries zero, so clearing it
  // whenever the state is not RUN covers IDLE and FILL consumes alike.
  assign rd_clr = !resetn || !dac_enable || (state_q != ST_RUN) || starve;

  ad_ip_jesd204_tpl_dac_fifo_mem #(
    .DATA_WIDTH (DMA_DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (push && dac_enable),
    .i_wr_addr (wr_ptr_q[DEPTH_LOG2-1:0]),
    .i_wr_data (s_axis_data),
    .i_rd_en   (pop),
    .i_rd_clr  (rd_clr),
    .i_rd_addr (rd_ptr_q[DEPTH_LOG2-1:0]),
    .o_rd_data (dac_ddata)
  );

  assign s_axis_ready = ready;
  assign dac_dunf     = dac_dunf_q;
  assign fifo_level   = level;

endmodule

`default_nettype wire

// File: tb/tb_ad_ip_jesd204_tpl_dac_dma_fifo.sv
//==============================================================================
// Module   : tb_ad_ip_jesd204_tpl_dac_dma_fifo
// Purpose  : Self-checking bench for the TPL DAC DMA elastic buffer. Every
//            consume strobe queues the expected {dunf, data}; a monitor pops
//            and compares on the following falling edge.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ad_ip_jesd204_tpl_dac_dma_fifo;

  localparam int W  = 32;
  localparam int DL = 4;
  localparam int PF = 8;

  logic          clk          = 1'b0;
  logic          resetn       = 1'b0;
  logic          dac_enable   = 1'b0;
  logic          s_axis_valid = 1'b0;
  logic [W-1:0]  s_axis_data  = '0;
  logic          dac_valid    = 1'b0;
  logic          s_axis_ready;
  logic [W-1:0]  dac_ddata;
  logic          dac_dunf;
  logic [DL:0]   fifo_level;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_dma_fifo #(
    .DMA_DATA_WIDTH (W),
    .DEPTH_LOG2     (DL),
    .PREFILL        (PF)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .dac_enable   (dac_enable),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_data  (s_axis_data),
    .dac_valid    (dac_valid),
    .dac_ddata    (dac_ddata),
    .dac_dunf     (dac_dunf),
    .fifo_level   (fifo_level)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // One clock edge with the given inputs; a consume strobe queues its
  // expected output word and underflow flag.
  task automatic cyc(input logic sv, input logic [W-1:0] sd, input logic dv,
                     input logic [W-1:0] ed, input logic eu);
    s_axis_valid = sv;
    s_axis_data  = sd;
    dac_valid    = dv;
    if (dv) exp_q.push_back({eu, ed});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // Scoreboard monitor
  initial begin : monitor
    logic       taken;
    logic [W:0] e;
    forever begin
      @(posedge clk);
      taken = dac_valid;
      @(negedge clk);
      if (taken) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_underrun: got 0x%0h expected no output", dac_ddata);
        end else begin
          e = exp_q.pop_front();
          chk("dac_ddata", 64'(dac_ddata), 64'(e[W-1:0]));
          chk("dac_dunf", 64'(dac_dunf), 64'(e[W]));
        end
      end else begin
        chk("dac_dunf_quiet", 64'(dac_dunf), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int in_idx;
    int out_idx;

    // Reset state
    repeat (3) idle_cyc();
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ready", 64'(s_axis_ready), 64'd0);
    chk("rst_ddata", 64'(dac_ddata), 64'd0);
    chk("rst_dunf", 64'(dac_dunf), 64'd0);
    resetn = 1'b1;
    idle_cyc();
    chk("idle_ready", 64'(s_axis_ready), 64'd0);

    // Prefill with continuous consume strobes: zeros until RUN, then 1..6
    dac_enable = 1'b1;
    cyc(1'b0, '0, 1'b1, '0, 1'b0);
    for (int i = 1; i <= 8; i++) cyc(1'b1, W'(i), 1'b1, '0, 1'b0);
    chk("prefill_level", 64'(fifo_level), 64'd8);
    cyc(1'b0, '0, 1'b1, '0, 1'b0);
    for (int i = 1; i <= 6; i++) cyc(1'b0, '0, 1'b1, W'(i), 1'b0);
    chk("run_level2", 64'(fifo_level), 64'd2);

    // Underflow: two words, then one zero-filled pulse, then quiet zeros
    cyc(1'b0, '0, 1'b1, W'(7), 1'b0);
    cyc(1'b0, '0, 1'b1, W'(8), 1'b0);
    cyc(1'b0, '0, 1'b1, '0, 1'b1);
    cyc(1'b0, '0, 1'b1, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, '0, 1'b0);
    // Back in FILL: a buffered word must not be released below threshold
    cyc(1'b1, W'(32'h20), 1'b1, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, '0, 1'b0);
    chk("refill_level", 64'(fifo_level), 64'd1);

    // Reach RUN with level 5, then reset mid-operation
    for (int i = 1; i <= 7; i++) cyc(1'b1, W'(32'h20 + i), 1'b0, '0, 1'b0);
    idle_cyc();
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, W'(32'h20 + i), 1'b0);
    chk("midrun_level", 64'(fifo_level), 64'd5);
    resetn = 1'b0;
    cyc(1'b0, '0, 1'b1, '0, 1'b0);
    chk("midrst_level", 64'(fifo_level), 64'd0);
    chk("midrst_ready", 64'(s_axis_ready), 64'd0);
    chk("midrst_ddata", 64'(dac_ddata), 64'd0);
    chk("midrst_dunf", 64'(dac_dunf), 64'd0);
    resetn = 1'b1;
    idle_cyc();
    chk("fill_ready", 64'(s_axis_ready), 64'd1);

    // Full: 16 accepted, word 16 held off until a pop frees a slot
    for (int i = 0; i < 16; i++) cyc(1'b1, W'(32'h100 + i), 1'b0, '0, 1'b0);
    chk("full_level", 64'(fifo_level), 64'd16);
    chk("full_ready", 64'(s_axis_ready), 64'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(32'h110), 1'b0, '0, 1'b0);
    chk("full_hold_level", 64'(fifo_level), 64'd16);
    cyc(1'b1, W'(32'h110), 1'b1, W'(32'h100), 1'b0);
    chk("full_pop_level", 64'(fifo_level), 64'd15);
    chk("full_pop_ready", 64'(s_axis_ready), 64'd1);
    cyc(1'b1, W'(32'h110), 1'b0, '0, 1'b0);
    chk("full_again_level", 64'(fifo_level), 64'd16);
    for (int i = 1; i <= 16; i++) cyc(1'b0, '0, 1'b1, W'(32'h100 + i), 1'b0);
    chk("drained_level", 64'(fifo_level), 64'd0);

    // Pointer wrap: 100 words, both sides stalling, level held at 4..5
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(i), 1'b0, '0, 1'b0);
    in_idx  = 4;
    out_idx = 0;
    for (int c = 0; c < 128; c++) begin
      cyc((c % 4) != 3, W'(in_idx), (c % 4) != 0, W'(out_idx), 1'b0);
      if ((c % 4) != 3) in_idx++;
      if ((c % 4) != 0) out_idx++;
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b1, W'(out_idx), 1'b0);
      out_idx++;
    end
    cyc(1'b0, '0, 1'b1, '0, 1'b1);
    chk("wrap_end_level", 64'(fifo_level), 64'd0);

    // Disable flush with level 10 and a live output word
    for (int i = 0; i < 11; i++) cyc(1'b1, W'(32'h200 + i), 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, W'(32'h200), 1'b0);
    chk("flush_pre_level", 64'(fifo_level), 64'd10);
    dac_enable = 1'b0;
    cyc(1'b1, W'(32'hDEAD), 1'b1, '0, 1'b0);
    chk("flush_level", 64'(fifo_level), 64'd0);
    chk("flush_ready", 64'(s_axis_ready), 64'd0);
    chk("flush_ddata", 64'(dac_ddata), 64'd0);
    dac_enable = 1'b1;
    idle_cyc();
    chk("reen_ready", 64'(s_axis_ready), 64'd1);
    chk("reen_level", 64'(fifo_level), 64'd0);
    for (int i = 0; i < 8; i++) cyc(1'b1, W'(32'h300 + i), 1'b1, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, W'(32'h300), 1'b0);
    cyc(1'b0, '0, 1'b1, W'(32'h301), 1'b0);
    chk("reen_run_level", 64'(fifo_level), 64'd6);

    repeat (3) idle_cyc();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
